// File: rtl/lite16_pkg.sv
// Shared definitions for the LITE-16 control path: widths, instruction field
// positions, the sequencer state type and small decode helpers.
package lite16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned IMM_W  = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [DATA_W-1:0] HALT_WORD = 16'hFFFF;

  // Instruction field positions (bit 15 selects ALU vs jump)
  localparam int unsigned IR_JMP     = 15;
  localparam int unsigned IR_COND    = 14;
  localparam int unsigned IR_TGT_W   = 14;
  localparam int unsigned IR_OP_LSB  = 12;
  localparam int unsigned IR_RI      = 11;
  localparam int unsigned IR_RD_LSB  = 8;
  localparam int unsigned IR_RA_LSB  = 5;
  localparam int unsigned IR_RB_LSB  = 2;
  localparam int unsigned IR_IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   codeop;
    logic              ri;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [IMM_W-1:0]  imm5;
  } alu_fields_t;

  function automatic alu_fields_t decode_alu(input logic [DATA_W-1:0] ir);
    alu_fields_t f;
    f.codeop = ir[IR_OP_LSB +: OP_W];
    f.ri     = ir[IR_RI];
    f.rd     = ir[IR_RD_LSB +: REG_AW];
    f.ra     = ir[IR_RA_LSB +: REG_AW];
    f.rb     = ir[IR_RB_LSB +: REG_AW];
    f.imm5   = ir[IR_IMM_LSB +: IMM_W];
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/cpu_control_regfile.sv
// 8x16 register file: three async read ports (ra, rb, rd), one sync write
// port; r0 always reads zero and ignores writes.
module regfile
  import lite16_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ra_addr_i,
  input  logic [REG_AW-1:0] rb_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
    rd_data_o = (rd_addr_i == '0) ? '0 : regs_q[rd_addr_i];
  end

endmodule

// File: rtl/cpu_control.sv
// LITE-16 multi-cycle sequencer: fetches over req/ack, decodes, drives the
// ALU from registered operands, writes results back and resolves jumps.
module cpu_control
  import lite16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [OP_W-1:0]   alu_codeop,
  output logic              alu_ri,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_cmp,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [OP_W-1:0]   codeop_q, codeop_d;
  logic              ri_q, ri_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rdv_q, rdv_d;

  alu_fields_t       dec;
  logic [DATA_W-1:0] rf_ra, rf_rb, rf_rd;
  logic              rf_we;

  assign dec   = decode_alu(ir_q);
  assign rf_we = (state_q == ST_WRITEBACK);

  regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .ra_addr_i (dec.ra),
    .rb_addr_i (dec.rb),
    .rd_addr_i (dec.rd),
    .ra_data_o (rf_ra),
    .rb_data_o (rf_rb),
    .rd_data_o (rf_rd),
    .we_i      (rf_we),
    .waddr_i   (dec.rd),
    .wdata_i   (result_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      flag_q   <= 1'b0;
      result_q <= '0;
      codeop_q <= '0;
      ri_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rdv_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_q   <= flag_d;
      result_q <= result_d;
      codeop_q <= codeop_d;
      ri_q     <= ri_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rdv_q    <= rdv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_d   = flag_q;
    result_d = result_q;
    codeop_d = codeop_q;
    ri_d     = ri_q;
    a_d      = a_q;
    b_d      = b_q;
    rdv_d    = rdv_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 16'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // HALT_WORD also has bit 15 set, so it must be tested before the jump decode
        if (ir_q == HALT_WORD) begin
          state_d = ST_HALT;
        end else if (ir_q[IR_JMP]) begin
          if (!ir_q[IR_COND] || flag_q) begin
            pc_d = {{(DATA_W-IR_TGT_W){1'b0}}, ir_q[IR_TGT_W-1:0]};
          end
          state_d = ST_FETCH;
        end else begin
          codeop_d = dec.codeop;
          ri_d     = dec.ri;
          a_d      = rf_ra;
          b_d      = dec.ri ? zext_imm(dec.imm5) : rf_rb;
          rdv_d    = rf_rd;
          state_d  = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        result_d = alu_r;
        flag_d   = alu_cmp;
        state_d  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imem_req   = (state_q == ST_FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign alu_codeop = codeop_q;
  assign alu_ri     = ri_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_rd     = rdv_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: directed program with literal expectations plus
// randomized programs/ack timing checked every cycle against an ISA-level model.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [2:0]  alu_codeop;
  logic        alu_ri;
  logic [15:0] alu_a, alu_b, alu_rd, alu_r;
  logic        alu_cmp;
  logic        halted;

  logic [15:0] mem [64];

  always #5 clk = ~clk;

  cpu_control dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_codeop (alu_codeop),
    .alu_ri     (alu_ri),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_rd     (alu_rd),
    .alu_r      (alu_r),
    .alu_cmp    (alu_cmp),
    .halted     (halted)
  );

  assign imem_data = mem[imem_addr[5:0]];

  // Stand-in ALU: {cmp, result}
  function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] rd);
    logic [15:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = rd + b;
      default: r = ~a;
    endcase
    return {(a < b), r};
  endfunction

  always_comb {alu_cmp, alu_r} = alu_fn(alu_codeop, alu_a, alu_b, alu_rd);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: each accepted fetch executes atomically; the
  // countdown only reproduces when its visible effects appear.
  logic [15:0] m_pc, m_regs [8];
  logic        m_flag, m_halt;
  int          m_left;
  int          p_kind;
  logic        p_take;
  logic [15:0] p_pc, p_a, p_b, p_rd;
  logic [2:0]  p_op;
  logic        p_ri;
  logic [15:0] e_a, e_b, e_rd;
  logic [2:0]  e_op;
  logic        e_ri;
  logic [15:0] w;
  logic [16:0] cr;

  task automatic model_reset();
    m_pc = '0; m_flag = 1'b0; m_halt = 1'b0; m_left = 0; p_kind = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    e_a = '0; e_b = '0; e_rd = '0; e_op = '0; e_ri = 1'b0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else if (!m_halt) begin
      if (m_left == 0) begin
        if (imem_ack) begin
          w = mem[m_pc[5:0]];
          m_pc = m_pc + 16'd1;
          if (w == 16'hFFFF) begin
            p_kind = 2; m_left = 1;
          end else if (w[15]) begin
            p_kind = 1; m_left = 1;
            p_take = !w[14] || m_flag;
            p_pc = {2'b00, w[13:0]};
          end else begin
            p_kind = 0; m_left = 3;
            p_op = w[14:12]; p_ri = w[11];
            p_a  = m_regs[w[7:5]];
            p_b  = w[11] ? {11'd0, w[4:0]} : m_regs[w[4:2]];
            p_rd = m_regs[w[10:8]];
            cr = alu_fn(p_op, p_a, p_b, p_rd);
            m_flag = cr[16];
            if (w[10:8] != 3'd0) m_regs[w[10:8]] = cr[15:0];
          end
        end
      end else begin
        if (p_kind == 0 && m_left == 3) begin
          e_op = p_op; e_ri = p_ri; e_a = p_a; e_b = p_b; e_rd = p_rd;
        end
        if (p_kind == 1 && p_take) m_pc = p_pc;
        if (p_kind == 2) m_halt = 1'b1;
        m_left--;
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",   {15'd0, imem_req}, {15'd0, (!rst && !m_halt && m_left == 0)});
      chk("imem_addr",  imem_addr, m_pc);
      chk("halted",     {15'd0, halted}, {15'd0, m_halt});
      chk("alu_codeop", {13'd0, alu_codeop}, {13'd0, e_op});
      chk("alu_ri",     {15'd0, alu_ri}, {15'd0, e_ri});
      chk("alu_a",      alu_a, e_a);
      chk("alu_b",      alu_b, e_b);
      chk("alu_rd",     alu_rd, e_rd);
    end
  end

  task automatic fill_random();
    int unsigned r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       mem[i] = 16'hFFFF;
      else if (r < 32) mem[i] = {1'b1, 1'($urandom_range(0, 1)), 8'd0, 6'($urandom_range(0, 63))};
      else             mem[i] = {1'b0, 15'($urandom)};
    end
  endtask

  initial begin
    int hw;
    rst = 1'b1;
    imem_ack = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 16'h0907;  // r1 = r0 + 7, cmp=1
    mem[1]  = 16'hC005;  // taken
    mem[5]  = 16'h0220;  // r2 = r1 + r0, cmp=0
    mem[6]  = 16'hC00A;  // not taken
    mem[7]  = 16'h8010;  // unconditional
    mem[16] = 16'h0805;  // write to r0 discarded
    mem[17] = 16'h0B01;  // reads r0
    mem[18] = 16'hFFFF;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_req",    {15'd0, imem_req}, 16'd0);
    chk("rst_addr",   imem_addr, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_alu_a",  alu_a, 16'h0000);
    chk("rst_alu_op", {13'd0, alu_codeop}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ack = 1'b1;

    for (int c = 0; c <= 44; c++) begin
      @(negedge clk);
      case (c)
        0:  begin chk("c0_req", {15'd0, imem_req}, 16'd1); chk("c0_addr", imem_addr, 16'h0000); end
        1:  chk("pc_after_fetch", imem_addr, 16'h0001);
        2:  begin
              chk("exec_codeop", {13'd0, alu_codeop}, 16'd0);
              chk("exec_ri", {15'd0, alu_ri}, 16'd1);
              chk("exec_b_imm", alu_b, 16'h0007);
              chk("exec_a_r0", alu_a, 16'h0000);
            end
        4:  begin chk("alu_4cyc_req", {15'd0, imem_req}, 16'd1); chk("alu_4cyc_addr", imem_addr, 16'h0001); end
        6:  chk("jmp_taken", imem_addr, 16'h0005);
        8:  begin chk("r1_readback", alu_a, 16'h0007); chk("reg_mode_ri", {15'd0, alu_ri}, 16'd0); end
        12: chk("jmp_not_taken", imem_addr, 16'h0007);
        14: chk("jmp_uncond", imem_addr, 16'h0010);
        20: chk("r0_stays_zero", alu_a, 16'h0000);
        23: chk("halt_not_yet", {15'd0, halted}, 16'd0);
        24: chk("halt_set", {15'd0, halted}, 16'd1);
        44: begin
              chk("halt_req_low", {15'd0, imem_req}, 16'd0);
              chk("halt_pc_frozen", imem_addr, 16'h0013);
              chk("halt_held", {15'd0, halted}, 16'd1);
            end
        default: ;
      endcase
      @(posedge clk); #1;
    end

    rst = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("rst_req_gate", {15'd0, imem_req}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      @(negedge clk);
      if (i == 0) chk("rst_clears_halt", {15'd0, halted}, 16'd0);
      chk("wait_req", {15'd0, imem_req}, 16'd1);
      chk("wait_addr", imem_addr, 16'h0000);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    @(negedge clk);
    chk("wait_pc_once", imem_addr, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    chk("rst_ack_req", {15'd0, imem_req}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("restart_addr", imem_addr, 16'h0000);
    chk("restart_req", {15'd0, imem_req}, 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_discarded", {15'd0, imem_req}, 16'd1);

    fill_random();
    hw = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (m_halt) hw++; else hw = 0;
      rst = (hw >= 20) || ($urandom_range(0, 249) == 0);
      if (rst) begin
        hw = 0;
        if ($urandom_range(0, 1) == 1) fill_random();
      end
      imem_ack = ($urandom_range(0, 99) < 55);
    end
    @(posedge clk); #1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multi-cycle sequencer that sits directly upstream of the ALU in the LITE-16 core. It fetches 16-bit instruction words over a request/acknowledge port and decodes them. It reads an internal 8×16 register file to drive the ALU's operand and control inputs, then writes the ALU result back. It also latches the ALU compare flag to resolve conditional jumps, and owns the program counter.

## Interface
- No parameters; data width fixed at 16, register count fixed at 8.
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  16  fetch word address (= pc)
- `imem_ack`  in  1  fetch data valid this cycle
- `imem_data`  in  16  instruction word
- `alu_codeop`  out  3  ALU operation select
- `alu_ri`  out  1  0 = register operand, 1 = immediate operand
- `alu_a`  out  16  operand A (= reg[ra])
- `alu_b`  out  16  operand B (reg[rb] or zero-extended imm5)
- `alu_rd`  out  16  current value of destination register
- `alu_r`  in  16  ALU result (combinational)
- `alu_cmp`  in  1  ALU compare output (combinational)
- `halted`  out  1  high in HALT state

## Operation
- Instruction format, bit 15 = 0 (ALU):
  - [14:12] codeop; [11] ri; [10:8] rd; [7:5] ra
  - ri=0: [4:2] rb; ri=1: imm5=[4:0]
- Bit 15 = 1 (jump): [14] cond; [13:0] target; new pc = {2'b00, target}.
- 16'hFFFF is HALT. It takes precedence over the jump decode.
- States:
  - FETCH: imem_req=1. On imem_ack, latch imem_data into ir, pc <= pc+1 (16-bit wrap, FFFF→0000), go to DECODE. Otherwise stay.
  - DECODE: HALT word → HALT. Jump → if cond=0, or cond=1 and flag=1, load pc; then go to FETCH. ALU → register alu_codeop/alu_ri/alu_a/alu_b/alu_rd from ir and the register file; go to EXECUTE.
  - EXECUTE: ALU outputs stable; latch alu_r into result and alu_cmp into flag; go to WRITEBACK.
  - WRITEBACK: reg[rd] <= result unless rd=0; go to FETCH.
  - HALT: terminal; only rst exits.
- r0 reads as 0 always; writes to r0 discarded.
- Reset values:
  - state FETCH; pc 0000; ir 0000; flag 0; result 0000; all registers 0000
  - all alu_* outputs 0; halted 0; imem_req 0 while rst high
- Registers read in DECODE reflect any WRITEBACK of the prior instruction; no forwarding needed, since stages never overlap.

## Timing
- imem_req = (state==FETCH) & ~rst; imem_addr = pc. Both hold until ack.
- imem_ack outside FETCH is ignored.
- Zero-wait ack (ack in the first FETCH cycle) is legal.
- ALU instruction: 4 cycles plus fetch wait states. Jump and HALT: 2 cycles plus wait states.
- alu_* outputs are registered: they change only on the DECODE→EXECUTE edge and hold their value through WRITEBACK and following non-ALU cycles.
- flag is updated only in EXECUTE. Jumps do not modify it.
- rst in any state, including mid-fetch with ack pending, returns all state to reset values on the next edge. A concurrent ack is discarded.
- A jump to the current fetch address (self-loop) is legal and repeats indefinitely.

## Structure
- Shared package `lite16_pkg`:
  - state enum
  - opcode field positions
  - HALT_WORD = 16'hFFFF
  - DATA_W = 16, REG_N = 8
- One sub-module, `regfile`: 8×16, two async read ports plus a third read port for rd, one sync write port, r0 hardwired 0. Everything else is in cpu_control.

## Test plan
- Reset then zero-wait memory. Program: ALU op codeop=000, ri=1, rd=1, imm5=7 → alu_codeop=000, alu_ri=1, alu_b=0007 in EXECUTE; reg1 = alu_r after WRITEBACK; pc=0001; 4 cycles total.
- Fetch wait states: ack delayed 3 cycles → imem_req and imem_addr held constant for 4 cycles; pc increments exactly once.
- Conditional jump: ALU op driving alu_cmp=1, then word C005 → pc=0005. Repeat with alu_cmp=0 → pc=previous+1. Unconditional 8010 → pc=0010 regardless of flag.
- Write to r0: ALU op rd=0 → subsequent ra=0 read gives alu_a=0000.
- HALT: word FFFF → halted=1 two cycles after ack; imem_req stays 0 and pc frozen for 20 cycles; rst clears halted.
- rst asserted during FETCH with imem_ack=1 in the same cycle → ir unchanged, pc=0000, state FETCH. Fetch restarts at address 0000 the cycle after rst falls.
